// File: rtl/ysyx_22051013_clint.sv
// ----------------------------------------------------------------------------
// ysyx_22051013_clint -- core-local interruptor
//
// Holds a free-running mtime counter, the mtimecmp compare value and the msip
// software-interrupt bit, and exposes them as a memory-mapped responder on the
// LSU data bus. The timer interrupt is a registered level driven by
// (mtime >= mtimecmp). The software interrupt is a registered copy of msip[0].
//
// Register map (byte offset from BASE_ADDR, 8-byte aligned):
//   0x0000 msip      (bit 0 only, upper bits read as 0)
//   0x4000 mtimecmp
//   0xBFF8 mtime
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   req_valid      in   LSU request valid
//   req_ready      out  block can accept a request (IDLE, out of reset)
//   req_wen        in   1 = store, 0 = load
//   req_addr       in   byte address
//   req_wdata      in   store data
//   req_wmask      in   store byte enables (bit i -> byte i)
//   resp_valid     out  response valid, held until resp_ready
//   resp_ready     in   LSU accepts response
//   resp_rdata     out  load data (0 for stores and unmapped loads)
//   resp_err       out  request address is not mapped
//   time_interrupt out  machine timer interrupt pending
//   soft_interrupt out  machine software interrupt pending
// ----------------------------------------------------------------------------
module ysyx_22051013_clint #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        time_interrupt,
  output logic        soft_interrupt
);

  localparam logic [63:0] ADDR_MSIP     = BASE_ADDR;
  localparam logic [63:0] ADDR_MTIMECMP = BASE_ADDR + 64'h0000_0000_0000_4000;
  localparam logic [63:0] ADDR_MTIME    = BASE_ADDR + 64'h0000_0000_0000_BFF8;
  localparam logic [31:0] TICK_LAST     = 32'(TICK_DIV - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;
  typedef enum logic [1:0] {
    SEL_MSIP = 2'd0, SEL_MTIMECMP = 2'd1, SEL_MTIME = 2'd2, SEL_NONE = 2'd3
  } sel_e;

  // Replace the bytes selected by mask, keep the rest of old_v.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  mask);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) res[8*i +: 8] = new_v[8*i +: 8];
      else         res[8*i +: 8] = old_v[8*i +: 8];
    end
    return res;
  endfunction

  state_e      r_state;
  state_e      w_state_next;
  logic        r_req_ready;
  logic        w_req_ready_next;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [31:0] r_presc;
  logic [63:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_time_irq;
  logic        r_soft_irq;

  logic        w_accept;
  logic        w_tick;
  sel_e        w_sel;
  logic [63:0] w_mtime_next;
  logic [63:0] w_mtimecmp_next;
  logic        w_msip_next;
  logic [63:0] w_rdata_next;
  logic        w_err_next;

  // r_req_ready is only ever 1 while in IDLE, so it alone qualifies acceptance.
  assign w_accept = req_valid & r_req_ready;
  assign w_tick   = (r_presc == TICK_LAST);

  // Address decode against the three mapped registers.
  always_comb begin
    if      (req_addr == ADDR_MSIP)     w_sel = SEL_MSIP;
    else if (req_addr == ADDR_MTIMECMP) w_sel = SEL_MTIMECMP;
    else if (req_addr == ADDR_MTIME)    w_sel = SEL_MTIME;
    else                                w_sel = SEL_NONE;
  end

  // FSM next state; req_ready is precomputed so it is low during reset.
  always_comb begin
    w_state_next     = r_state;
    w_req_ready_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next     = ST_RESP;
          w_req_ready_next = 1'b0;
        end else begin
          w_state_next     = ST_IDLE;
          w_req_ready_next = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_next     = ST_IDLE;
          w_req_ready_next = 1'b1;
        end else begin
          w_state_next     = ST_RESP;
          w_req_ready_next = 1'b0;
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_req_ready_next = 1'b1;
      end
    endcase
  end

  // Register access: loads see pre-edge values; a real store to mtime beats the tick.
  always_comb begin
    w_rdata_next    = 64'd0;
    w_err_next      = 1'b0;
    w_msip_next     = r_msip;
    w_mtimecmp_next = r_mtimecmp;
    w_mtime_next    = w_tick ? (r_mtime + 64'd1) : r_mtime;
    if (w_accept) begin
      case (w_sel)
        SEL_MSIP: begin
          w_rdata_next = req_wen ? 64'd0 : {63'd0, r_msip};
          w_msip_next  = (req_wen && req_wmask[0]) ? req_wdata[0] : r_msip;
        end
        SEL_MTIMECMP: begin
          w_rdata_next    = req_wen ? 64'd0 : r_mtimecmp;
          w_mtimecmp_next = req_wen ? merge_bytes(r_mtimecmp, req_wdata, req_wmask)
                                    : r_mtimecmp;
        end
        SEL_MTIME: begin
          w_rdata_next = req_wen ? 64'd0 : r_mtime;
          if (req_wen && (req_wmask != 8'h00)) begin
            w_mtime_next = merge_bytes(r_mtime, req_wdata, req_wmask);
          end else begin
            w_mtime_next = w_tick ? (r_mtime + 64'd1) : r_mtime;
          end
        end
        default: begin
          w_rdata_next = 64'd0;
          w_err_next   = 1'b1;
        end
      endcase
    end else begin
      w_rdata_next = 64'd0;
      w_err_next   = 1'b0;
    end
  end

  // FSM state and request-ready register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= w_req_ready_next;
    end
  end

  // Timer prescaler, architectural registers and interrupt levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc    <= 32'd0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
      r_time_irq <= 1'b0;
      r_soft_irq <= 1'b0;
    end else begin
      r_presc    <= w_tick ? 32'd0 : (r_presc + 32'd1);
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_mtimecmp_next;
      r_msip     <= w_msip_next;
      r_time_irq <= (r_mtime >= r_mtimecmp);
      r_soft_irq <= r_msip;
    end
  end

  // Response payload, captured at the accepting edge and held through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_resp_rdata <= w_rdata_next;
      r_resp_err   <= w_err_next;
    end else begin
      r_resp_rdata <= r_resp_rdata;
      r_resp_err   <= r_resp_err;
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = (r_state == ST_RESP);
  assign resp_rdata     = r_resp_rdata;
  assign resp_err       = r_resp_err;
  assign time_interrupt = r_time_irq;
  assign soft_interrupt = r_soft_irq;

endmodule
